// File: rtl/led_indicator_scheduler.sv
// Indicator scheduler: debounced stability level shown by default, round-robin
// shared with event requesters that each get a blinking display slot.
module led_indicator_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int EVENT_HOLD = 100000000,
    parameter int DWELL      = 12500000,
    parameter int CNT_W      = 27
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             level,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_color,
    output logic [NUM_REQ-1:0]     ack,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic [2:0]             color_sel,
    output logic                   blink_en
);

    typedef enum logic {STEADY, EVENT} state_t;

    state_t               state_q, state_d;
    logic [1:0]           lvl_q, lvl_d, lvl_prev_q;
    logic [CNT_W-1:0]     dwell_q, dwell_d, dwell_nxt;
    logic [CNT_W-1:0]     hold_q, hold_d;
    logic [2:0]           rr_q, rr_d;
    logic [NUM_REQ-1:0]   ack_d, win_oh;
    logic [2:0]           grant_d, win_id, win_rr;
    logic [2:0]           color_d, win_color;
    logic                 busy_d, blink_d, found, do_grant;

    function automatic logic [2:0] lvl_color(input logic [1:0] l);
        case (l)
            2'd0:    lvl_color = 3'b010;
            2'd1:    lvl_color = 3'b110;
            default: lvl_color = 3'b100;
        endcase
    endfunction

    // Level filter: a new level must persist DWELL consecutive cycles
    always_comb begin
        lvl_d     = lvl_q;
        dwell_nxt = (level == lvl_prev_q) ? dwell_q + CNT_W'(1) : CNT_W'(1);
        dwell_d   = dwell_nxt;
        if (level == lvl_q) begin
            dwell_d = '0;
        end else if (dwell_nxt >= CNT_W'(DWELL)) begin
            lvl_d   = level;
            dwell_d = '0;
        end
    end

    // Round-robin search: first pass from the pointer upward, second pass wraps
    always_comb begin
        found     = 1'b0;
        win_oh    = '0;
        win_id    = '0;
        win_rr    = '0;
        win_color = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && j >= int'(rr_q)) begin
                found     = 1'b1;
                win_oh[j] = 1'b1;
                win_id    = 3'(j);
                win_rr    = (j == NUM_REQ - 1) ? 3'd0 : 3'(j + 1);
                win_color = req_color[3*j +: 3];
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j]) begin
                found     = 1'b1;
                win_oh[j] = 1'b1;
                win_id    = 3'(j);
                win_rr    = (j == NUM_REQ - 1) ? 3'd0 : 3'(j + 1);
                win_color = req_color[3*j +: 3];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        rr_d     = rr_q;
        ack_d    = '0;
        grant_d  = grant_id;
        busy_d   = busy;
        color_d  = color_sel;
        blink_d  = blink_en;
        do_grant = 1'b0;
        case (state_q)
            STEADY: begin
                color_d  = lvl_color(lvl_q);
                blink_d  = (lvl_q == 2'd3);
                busy_d   = 1'b0;
                do_grant = found;
            end
            EVENT: begin
                if (hold_q == '0) begin
                    if (found) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = STEADY;
                        busy_d  = 1'b0;
                        color_d = lvl_color(lvl_q);
                        blink_d = (lvl_q == 2'd3);
                    end
                end else begin
                    hold_d = hold_q - CNT_W'(1);
                end
            end
            default: state_d = STEADY;
        endcase
        // Hold counter counts down to zero on the last displayed event cycle
        if (do_grant) begin
            state_d = EVENT;
            hold_d  = CNT_W'(EVENT_HOLD - 1);
            ack_d   = win_oh;
            grant_d = win_id;
            busy_d  = 1'b1;
            blink_d = 1'b1;
            color_d = win_color;
            rr_d    = win_rr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= STEADY;
            lvl_q      <= 2'd0;
            lvl_prev_q <= 2'd0;
            dwell_q    <= '0;
            hold_q     <= '0;
            rr_q       <= 3'd0;
            ack        <= '0;
            grant_id   <= 3'd0;
            busy       <= 1'b0;
            color_sel  <= 3'b010;
            blink_en   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= level;
            dwell_q    <= dwell_d;
            hold_q     <= hold_d;
            rr_q       <= rr_d;
            ack        <= ack_d;
            grant_id   <= grant_d;
            busy       <= busy_d;
            color_sel  <= color_d;
            blink_en   <= blink_d;
        end
    end

endmodule

// File: tb/tb_led_indicator_scheduler.sv
// Scoreboard bench: a behavioural model queues the expected outputs after every
// clock edge; a monitor pops and compares them on the falling edge.
module tb_led_indicator_scheduler;

    localparam int N    = 4;
    localparam int HOLD = 8;
    localparam int DW   = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   level = 2'd0;
    logic [N-1:0] req = '0;
    logic [3*N-1:0] req_color = '0;
    logic [N-1:0] ack;
    logic [2:0]   grant_id;
    logic         busy;
    logic [2:0]   color_sel;
    logic         blink_en;

    bit auto_drop = 1'b1;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]   color;
        logic         blink;
        logic         busy;
        logic [N-1:0] ack;
        logic [2:0]   gid;
    } exp_t;

    exp_t exp_q[$];

    led_indicator_scheduler #(
        .NUM_REQ(N), .EVENT_HOLD(HOLD), .DWELL(DW), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .level(level), .req(req), .req_color(req_color),
        .ack(ack), .grant_id(grant_id), .busy(busy),
        .color_sel(color_sel), .blink_en(blink_en)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] rgb_of(input int l);
        case (l)
            0:       return 3'b010;
            1:       return 3'b110;
            default: return 3'b100;
        endcase
    endfunction

    // Reference model: displayed level, remaining event cycles, RR pointer
    int         m_shown, m_run_lvl, m_run_len, m_ptr, m_left, m_gid;
    logic [2:0] m_color;
    logic       m_blink, m_busy;

    always @(posedge clk) begin
        exp_t e;
        int rq, c, win;
        e.ack = '0;
        if (rst) begin
            m_shown = 0; m_run_lvl = 0; m_run_len = 0; m_ptr = 0; m_left = 0;
            m_gid = 0; m_color = 3'b010; m_blink = 1'b0; m_busy = 1'b0;
        end else begin
            rq  = int'(req);
            win = -1;
            if (m_left <= 1 && rq != 0) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (win < 0 && ((rq >> c) & 1) == 1) win = c;
                end
            end
            if (win >= 0) begin
                e.ack   = N'(1 << win);
                m_gid   = win;
                m_color = 3'((int'(req_color) >> (3 * win)) & 7);
                m_blink = 1'b1;
                m_busy  = 1'b1;
                m_left  = HOLD;
                m_ptr   = (win + 1) % N;
            end else if (m_left > 1) begin
                m_left = m_left - 1;
            end else begin
                m_left  = 0;
                m_color = rgb_of(m_shown);
                m_blink = (m_shown == 3);
                m_busy  = 1'b0;
            end
            if (int'(level) == m_run_lvl) m_run_len = m_run_len + 1;
            else begin
                m_run_lvl = int'(level);
                m_run_len = 1;
            end
            if (m_run_lvl != m_shown && m_run_len >= DW) m_shown = m_run_lvl;
        end
        e.color = m_color;
        e.blink = m_blink;
        e.busy  = m_busy;
        e.gid   = 3'(m_gid);
        exp_q.push_back(e);
    end

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("color_sel", int'(color_sel), int'(e.color));
            chk("blink_en",  int'(blink_en),  int'(e.blink));
            chk("busy",      int'(busy),      int'(e.busy));
            chk("ack",       int'(ack),       int'(e.ack));
            chk("grant_id",  int'(grant_id),  int'(e.gid));
        end
    end

    task automatic cyc();
        @(negedge clk);
        if (auto_drop) req = req & ~ack;
    endtask

    initial begin
        int lvl_hold;
        lvl_hold = 0;
        repeat (3) cyc();
        rst = 1'b0;
        repeat (5) cyc();

        // level filter: full dwell, short glitch, fault level
        level = 2'd2; repeat (7) cyc();
        level = 2'd0; repeat (6) cyc();
        level = 2'd2; repeat (3) cyc();
        level = 2'd0; repeat (5) cyc();
        level = 2'd3; repeat (8) cyc();
        level = 2'd0; repeat (6) cyc();

        // single event from requester 1 with color 001
        req_color = 12'h008;
        req = 4'b0010; repeat (12) cyc();

        // all requesters held continuously
        rst = 1'b1; cyc(); rst = 1'b0;
        auto_drop = 1'b0;
        req_color = 12'h9A5;
        req = 4'hF; repeat (45) cyc();
        req = '0; auto_drop = 1'b1; repeat (10) cyc();

        // level change during an event; requester 2 pulses and withdraws
        req = 4'b0001; cyc();
        level = 2'd1; cyc(); cyc();
        req = req | 4'b0100; cyc();
        req = req & 4'b1011; repeat (12) cyc();
        level = 2'd0; repeat (8) cyc();

        // reset in the middle of an event, then pointer must start from 0
        req_color = 12'h0C0;
        req = 4'b0010; repeat (4) cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        req = 4'b1010; repeat (20) cyc();
        req = 4'b1000; repeat (12) cyc();

        // randomized traffic
        repeat (600) begin
            cyc();
            rst = 1'b0;
            if (lvl_hold == 0) begin
                level    = 2'($urandom_range(0, 3));
                lvl_hold = $urandom_range(1, 7);
            end else begin
                lvl_hold--;
            end
            for (int i = 0; i < N; i++) begin
                if (((int'(req) >> i) & 1) == 0) begin
                    if ($urandom_range(0, 9) == 0) begin
                        req_color = (req_color & ~(12'h7 << (3 * i)))
                                  | (12'($urandom_range(0, 7)) << (3 * i));
                        req = req | N'(1 << i);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req = req & ~N'(1 << i);
                end
            end
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
        end
        rst = 1'b0; req = '0; level = 2'd0;
        repeat (12) cyc();
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
